data_rw_word_initiator: RTL

Initiator side of the byte-wide simulation data port: turns word-wide read/write requests from a core into sequential byte accesses on that port. It drives address, write enable and write data, and collects the registered read byte the memory model returns one cycle later. Each access reads before it writes, so every request, write or read, returns the word's prior contents. It sits between a core's data bus and the byte-wide simulated memory.

---
 rtl/data_rw_word_initiator.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/data_rw_word_initiator.sv
// data_rw_word_initiator: splits word read/write requests into sequential byte accesses
// on a byte-wide registered memory port; every request returns the word's prior contents.
`default_nettype none

module data_rw_word_initiator #(
  parameter int NBYTES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  input  logic [NBYTES-1:0]     req_wmask,
  input  logic [8*NBYTES-1:0]   req_wdata,
  output logic                  resp_valid,
  output logic [8*NBYTES-1:0]   resp_rdata,
  output logic [31:0]           mem_addr,
  output logic                  mem_wenable,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata
);

  localparam int          KW        = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [31:0] ADDR_MASK = ~(32'(NBYTES) - 32'd1);
  localparam logic [KW-1:0] K_LAST  = KW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic [31:0]           base_q, base_d;
  logic [NBYTES-1:0]     wmask_q, wmask_d;
  logic [8*NBYTES-1:0]   wdata_q, wdata_d;
  logic                  cap_v_q, cap_v_d;
  logic [KW-1:0]         cap_k_q, cap_k_d;
  logic [8*NBYTES-1:0]   shadow_q, shadow_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [8*NBYTES-1:0]   resp_rdata_q, resp_rdata_d;
  logic [31:0]           mem_addr_q, mem_addr_d;
  logic                  mem_wen_q, mem_wen_d;
  logic [7:0]            mem_wdata_q, mem_wdata_d;
  logic                  accept;
  logic [KW-1:0]         k_nxt;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    base_d       = base_q;
    wmask_d      = wmask_q;
    wdata_d      = wdata_q;
    shadow_d     = shadow_q;
    resp_rdata_d = resp_rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wen_d    = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    accept       = req_valid && req_ready_q;
    k_nxt        = k_q + 1'b1;

    // The byte presented two edges ago is on mem_rdata now.
    if (cap_v_q) begin
      shadow_d[{cap_k_q, 3'b000} +: 8] = mem_rdata;
    end

    case (state_q)
      S_IDLE, S_RESP: begin
        if (accept) begin
          state_d     = S_ISSUE;
          base_d      = req_addr & ADDR_MASK;
          wmask_d     = req_wmask;
          wdata_d     = req_wdata;
          k_d         = '0;
          mem_addr_d  = req_addr & ADDR_MASK;
          mem_wen_d   = req_wmask[0];
          mem_wdata_d = req_wdata[7:0];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
        end else begin
          k_d         = k_nxt;
          mem_addr_d  = base_q | 32'(k_nxt);
          mem_wen_d   = wmask_q[k_nxt];
          mem_wdata_d = wdata_q[{k_nxt, 3'b000} +: 8];
        end
      end
      S_DRAIN: begin
        state_d      = S_RESP;
        resp_rdata_d = shadow_d;
      end
      default: state_d = S_IDLE;
    endcase

    cap_v_d      = (state_q == S_ISSUE);
    cap_k_d      = k_q;
    req_ready_d  = (state_d == S_IDLE) || (state_d == S_RESP);
    resp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      base_q       <= '0;
      wmask_q      <= '0;
      wdata_q      <= '0;
      cap_v_q      <= 1'b0;
      cap_k_q      <= '0;
      shadow_q     <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_wen_q    <= 1'b0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      base_q       <= base_d;
      wmask_q      <= wmask_d;
      wdata_q      <= wdata_d;
      cap_v_q      <= cap_v_d;
      cap_k_q      <= cap_k_d;
      shadow_q     <= shadow_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wen_q    <= mem_wen_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wenable = mem_wen_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

`default_nettype wire
